dram_req_ctrl: RTL and testbench

Request controller between the L2 miss/write-back path and the `dram` model. It accepts line-sized read and write requests from L2, posts writes into a small write buffer, and gives reads priority. It serializes everything onto the DRAM single-pulse `mem_rd`/`mem_wr`/`mem_ready` interface, with at most one DRAM operation in flight.

---
 rtl/dram_req_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dram_req_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_ctrl.sv
// dram_req_ctrl
//   Request controller between the L2 miss/write-back path and the DRAM model.
//   Line-sized writes are posted into a small FIFO write buffer. Reads take
//   priority over buffered writes unless they hit a buffered line. Everything
//   is serialized onto the single-pulse mem_rd/mem_wr/mem_ready interface,
//   with at most one DRAM operation in flight.
//
//   Build option: DRAM_REQ_WB_FORWARD_EN
//     defined   - a read hitting a buffered line is answered from the youngest
//                 matching entry, with no DRAM access.
//     undefined - a hitting read drains head writes until no match remains,
//                 then reads DRAM. There is no forwarding datapath.
//
//   Ports
//     clk, rst_n             clock (rising edge), async active-low reset
//     req_valid/req_ready    L2 request handshake
//     req_rd                 1 = read, 0 = write
//     req_addr, req_wdata    byte address (line = [31:6]) and write line data
//     resp_valid/resp_rdata  one-cycle read response pulse with line data
//     mem_addr/mem_wdata     DRAM address (line aligned) and write data
//     mem_rd/mem_wr          single-cycle DRAM command pulses
//     mem_rdata/mem_ready    DRAM read data and completion pulse
//     wb_count               occupied write-buffer entries
module dram_req_ctrl #(
  parameter int unsigned LINE_SIZE = 64,
  parameter int unsigned WB_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic                         req_rd,
  input  logic [31:0]                  req_addr,
  input  logic [LINE_SIZE*8-1:0]       req_wdata,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic [LINE_SIZE*8-1:0]       resp_rdata,
  output logic [31:0]                  mem_addr,
  output logic [LINE_SIZE*8-1:0]       mem_wdata,
  output logic                         mem_rd,
  output logic                         mem_wr,
  input  logic [LINE_SIZE*8-1:0]       mem_rdata,
  input  logic                         mem_ready,
  output logic [$clog2(WB_DEPTH):0]    wb_count
);

  localparam int unsigned LW = LINE_SIZE * 8;
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR, RESP} state_t;

  state_t          state;
  logic            rd_pending;
  logic [25:0]     rd_line;
  logic [25:0]     wb_line [WB_DEPTH];
  logic [LW-1:0]   wb_data [WB_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            wb_full;
  logic            push;
  logic            rd_acc;
  logic            pop;
  logic            match;
`ifdef DRAM_REQ_WB_FORWARD_EN
  logic [PW-1:0]   match_idx;
`endif
  logic            unused_addr_bits;

  assign unused_addr_bits = ^req_addr[5:0];

  assign wb_full   = (wb_count == CW'(WB_DEPTH));
  assign req_ready = !rd_pending && !wb_full;
  assign push      = req_valid && req_ready && !req_rd;
  assign rd_acc    = req_valid && req_ready && req_rd;
  // An entry leaves the buffer only when its own write completes, so an
  // in-flight write still participates in matching.
  assign pop       = (state == WAIT_WR) && mem_ready;

  // Scan oldest to youngest; the last hit is the youngest matching entry.
  always_comb begin
    logic [PW-1:0] idx;
    idx   = head;
    match = 1'b0;
`ifdef DRAM_REQ_WB_FORWARD_EN
    match_idx = head;
`endif
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      idx = head + k[PW-1:0];
      if (k < 32'(wb_count) && wb_line[idx] == rd_line) begin
        match = 1'b1;
`ifdef DRAM_REQ_WB_FORWARD_EN
        match_idx = idx;
`endif
      end
    end
  end

  // Buffer storage needs no reset: validity is carried by wb_count.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_line[tail] <= req_addr[31:6];
      wb_data[tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_pending <= 1'b0;
      rd_line    <= '0;
      head       <= '0;
      tail       <= '0;
      wb_count   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      resp_valid <= 1'b0;

      if (rd_acc) begin
        rd_pending <= 1'b1;
        rd_line    <= req_addr[31:6];
      end

      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   wb_count <= wb_count + CW'(1);
        2'b01:   wb_count <= wb_count - CW'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (rd_pending && match) begin
`ifdef DRAM_REQ_WB_FORWARD_EN
            resp_rdata <= wb_data[match_idx];
            state      <= RESP;
`else
            mem_wr    <= 1'b1;
            mem_addr  <= {wb_line[head], 6'b0};
            mem_wdata <= wb_data[head];
            state     <= WAIT_WR;
`endif
          end else if (rd_pending) begin
            mem_rd   <= 1'b1;
            mem_addr <= {rd_line, 6'b0};
            state    <= WAIT_RD;
          end else if (wb_count != '0) begin
            mem_wr    <= 1'b1;
            mem_addr  <= {wb_line[head], 6'b0};
            mem_wdata <= wb_data[head];
            state     <= WAIT_WR;
          end
        end
        WAIT_RD: begin
          if (mem_ready) begin
            resp_rdata <= mem_rdata;
            state      <= RESP;
          end
        end
        WAIT_WR: begin
          if (mem_ready) state <= IDLE;
        end
        RESP: begin
          resp_valid <= 1'b1;
          rd_pending <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Bench for dram_req_ctrl: directed scenarios plus randomized traffic checked
// against a line-level memory model. Includes a fixed-latency DRAM model.
module tb_dram_req_ctrl;
  localparam int unsigned LINE_SIZE = 64;
  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned LW        = LINE_SIZE * 8;
  localparam int          LAT       = 10;
`ifdef DRAM_REQ_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef logic [LW-1:0] line_t;
  typedef struct { int cyc; bit wr; logic [31:0] addr; line_t data; } mev_t;
  typedef struct { int cyc; line_t data; } rev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rd = 1'b0;
  logic [31:0] req_addr = '0;
  line_t       req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  line_t       resp_rdata;
  logic [31:0] mem_addr;
  line_t       mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  line_t       mem_rdata;
  logic        mem_ready;
  logic [$clog2(WB_DEPTH):0] wb_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int proto_err = 0;

  mev_t  mq[$];
  rev_t  rq[$];
  int    rdyq[$];
  line_t expq[$];

  line_t ref_mem [128];
  bit    ref_valid [128];

  dram_req_ctrl #(.LINE_SIZE(LINE_SIZE), .WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .wb_count(wb_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic line_t init_line(input int unsigned idx);
    line_t d;
    for (int i = 0; i < int'(LW / 32); i++)
      d[i*32 +: 32] = 32'(idx << 6) ^ (32'h9E37_79B9 * 32'(i + 1));
    return d;
  endfunction

  function automatic line_t rand_line();
    line_t d;
    for (int i = 0; i < int'(LW / 32); i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int unsigned lidx(input logic [31:0] a);
    return 32'(a[12:6]);
  endfunction

  // DRAM model: mem_ready pulses LAT cycles after the command pulse.
  logic        dram_busy;
  int          dram_cnt;
  bit          op_wr;
  int unsigned op_idx;
  line_t       op_data;
  line_t       dmem [128];
  bit          dvalid [128];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      dram_busy <= 1'b0;
      dram_cnt  <= 0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= 1'b0;
      if (dram_busy) begin
        if (dram_cnt <= 1) begin
          mem_ready <= 1'b1;
          dram_busy <= 1'b0;
          if (op_wr) begin
            dmem[op_idx]   <= op_data;
            dvalid[op_idx] <= 1'b1;
          end else begin
            mem_rdata <= dvalid[op_idx] ? dmem[op_idx] : init_line(op_idx);
          end
        end else begin
          dram_cnt <= dram_cnt - 1;
        end
      end else if (mem_rd || mem_wr) begin
        dram_busy <= 1'b1;
        dram_cnt  <= LAT - 1;
        op_wr     <= mem_wr;
        op_idx    <= 32'(mem_addr[12:6]);
        op_data   <= mem_wdata;
      end
    end
  end

  // Event logger and interface-rule monitor, sampled mid-cycle.
  bit outstanding = 1'b0;
  bit prev_pulse  = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
      prev_pulse  <= 1'b0;
    end else begin
      if (mem_rd || mem_wr) mq.push_back('{cyc, mem_wr, mem_addr, mem_wdata});
      if (resp_valid) rq.push_back('{cyc, resp_rdata});
      if (mem_ready) rdyq.push_back(cyc);
      if ((mem_rd && mem_wr) ||
          ((mem_rd || mem_wr) && (prev_pulse || outstanding || mem_addr[5:0] != 6'd0))) begin
        proto_err <= proto_err + 1;
        $display("protocol violation at cyc %0d: rd=%0b wr=%0b addr=%h prev=%0b busy=%0b",
                 cyc, mem_rd, mem_wr, mem_addr, prev_pulse, outstanding);
      end
      prev_pulse  <= mem_rd || mem_wr;
      outstanding <= (mem_rd || mem_wr) ? 1'b1 : (mem_ready ? 1'b0 : outstanding);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic clear_logs();
    mq.delete(); rq.delete(); rdyq.delete(); expq.delete();
  endtask

  // Present one request from a negedge; returns the accepting edge number.
  task automatic send(input bit rd, input logic [31:0] addr, input line_t data, output int acc);
    int n;
    n = 0;
    req_valid = 1'b1; req_rd = rd; req_addr = addr; req_wdata = data;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    n_cmp++;
    if (!req_ready) begin
      n_err++;
      $display("FAIL send_accept: req_ready=%0b required 1 within 500 cycles (addr %h)", req_ready, addr);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (rd) expq.push_back(ref_valid[lidx(addr)] ? ref_mem[lidx(addr)] : init_line(lidx(addr)));
    else begin
      ref_mem[lidx(addr)]   = data;
      ref_valid[lidx(addr)] = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    int quiet;
    n = 0; quiet = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk); n++;
      if (wb_count == 0 && req_ready && !dram_busy && !mem_ready && !mem_rd && !mem_wr && !resp_valid)
        quiet++;
      else
        quiet = 0;
    end
    n_cmp++;
    if (quiet < 3) begin
      n_err++;
      $display("FAIL %s_drain: idle cycles=%0d required 3 within 3000", tag, quiet);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %0b required 1", req_ready); end
    n_cmp++; if ({resp_valid, mem_rd, mem_wr} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b required 000", {resp_valid, mem_rd, mem_wr}); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    n_cmp++; if (resp_rdata !== '0) begin n_err++; $display("FAIL reset_resp_rdata: got %h required 0", resp_rdata); end
    n_cmp++; if (wb_count !== 3'd0) begin n_err++; $display("FAIL reset_wb_count: got %0d required 0", wb_count); end
  endtask

  task automatic test_single_read();
    int a;
    clear_logs();
    send(1'b1, 32'h40, '0, a);
    wait_idle("single_read");
    n_cmp++;
    if (mq.size() != 1 || mq[0].wr || mq[0].addr !== 32'h40 || mq[0].cyc != a + 1) begin
      n_err++;
      $display("FAIL single_read_cmd: got %0d cmds (first wr=%0b addr=%h cyc=%0d) required 1 rd @40 cyc %0d",
               mq.size(), mq.size() > 0 ? mq[0].wr : 1'b0, mq.size() > 0 ? mq[0].addr : 32'h0,
               mq.size() > 0 ? mq[0].cyc : -1, a + 1);
    end
    n_cmp++;
    if (rq.size() != 1) begin
      n_err++; $display("FAIL single_read_resp_count: got %0d required 1", rq.size());
    end else begin
      n_cmp++;
      if (rq[0].cyc - a != LAT + 3) begin n_err++; $display("FAIL single_read_latency: got %0d required %0d", rq[0].cyc - a, LAT + 3); end
      n_cmp++;
      if (rq[0].data !== init_line(1)) begin n_err++; $display("FAIL single_read_data: got %h required %h", rq[0].data, init_line(1)); end
    end
  endtask

  task automatic test_wb_fill();
    int    a, a0, c;
    bit    held;
    line_t d[4];
    clear_logs();
    a0 = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = rand_line();
      send(1'b0, 32'h100 + 32'(i) * 32'h40, d[i], a);
      if (i == 0) a0 = a;
    end
    n_cmp++; if (wb_count !== 3'd4) begin n_err++; $display("FAIL wb_fill_count: got %0d required 4", wb_count); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wb_fill_full_ready: got %0b required 0", req_ready); end
    held = 1'b1; c = -1;
    for (int n = 0; n < 100; n++) begin
      if (req_ready) begin c = cyc; break; end
      if (wb_count !== 3'd4) held = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (c != a0 + LAT + 2) begin n_err++; $display("FAIL wb_fill_ready_return: got cyc %0d required %0d", c, a0 + LAT + 2); end
    n_cmp++; if (!held) begin n_err++; $display("FAIL wb_fill_count_held: got changed required 4 while full"); end
    wait_idle("wb_fill");
    n_cmp++; if (mq.size() != 4) begin n_err++; $display("FAIL wb_fill_cmd_count: got %0d required 4", mq.size()); end
    for (int i = 0; i < 4 && i < mq.size(); i++) begin
      n_cmp++;
      if (!mq[i].wr || mq[i].addr !== 32'h100 + 32'(i) * 32'h40 || mq[i].data !== d[i] ||
          mq[i].cyc != a0 + 1 + i * (LAT + 2)) begin
        n_err++;
        $display("FAIL wb_fill_write%0d: got wr=%0b addr=%h cyc=%0d required wr=1 addr=%h cyc=%0d",
                 i, mq[i].wr, mq[i].addr, mq[i].cyc, 32'h100 + 32'(i) * 32'h40, a0 + 1 + i * (LAT + 2));
      end
    end
  endtask

  task automatic test_write_read();
    int    a, a1, a2, wr_pos, rd_pos, rd_cnt;
    line_t dd;
    clear_logs();
    send(1'b0, 32'h2C0, rand_line(), a);
    dd = rand_line();
    send(1'b0, 32'h200, dd, a1);
    send(1'b1, 32'h200, '0, a2);
    wait_idle("write_read");
    wr_pos = -1; rd_pos = -1; rd_cnt = 0;
    foreach (mq[i]) begin
      if (mq[i].addr === 32'h200 && mq[i].wr && wr_pos < 0) wr_pos = i;
      if (mq[i].addr === 32'h200 && !mq[i].wr) begin rd_cnt++; rd_pos = i; end
    end
    n_cmp++; if (rd_cnt != (FWD ? 0 : 1)) begin n_err++; $display("FAIL write_read_rd_count: got %0d required %0d", rd_cnt, FWD ? 0 : 1); end
    n_cmp++;
    if (wr_pos < 0 || !(FWD || wr_pos < rd_pos)) begin
      n_err++; $display("FAIL write_read_order: got wr_pos=%0d rd_pos=%0d required write first", wr_pos, rd_pos);
    end
    n_cmp++;
    if (rq.size() != 1) begin
      n_err++; $display("FAIL write_read_resp_count: got %0d required 1", rq.size());
    end else begin
      n_cmp++;
      if (rq[0].data !== dd) begin n_err++; $display("FAIL write_read_data: got %h required %h", rq[0].data, dd); end
      n_cmp++;
      if (rq[0].cyc != (FWD ? a + LAT + 4 : a + 3 * LAT + 7)) begin
        n_err++; $display("FAIL write_read_resp_cyc: got %0d required %0d", rq[0].cyc, FWD ? a + LAT + 4 : a + 3 * LAT + 7);
      end
    end
  endtask

  task automatic test_read_priority();
    int          a, a1, a2;
    logic [31:0] ea [3];
    bit          ew [3];
    int          ec [3];
    clear_logs();
    send(1'b0, 32'h300, rand_line(), a);
    send(1'b0, 32'h340, rand_line(), a1);
    send(1'b1, 32'h1000, '0, a2);
    wait_idle("read_priority");
    ea[0] = 32'h300;  ew[0] = 1'b1; ec[0] = a + 1;
    ea[1] = 32'h1000; ew[1] = 1'b0; ec[1] = a + LAT + 3;
    ea[2] = 32'h340;  ew[2] = 1'b1; ec[2] = a + 2 * LAT + 6;
    n_cmp++; if (mq.size() != 3) begin n_err++; $display("FAIL read_priority_cmd_count: got %0d required 3", mq.size()); end
    for (int i = 0; i < 3 && i < mq.size(); i++) begin
      n_cmp++;
      if (mq[i].wr != ew[i] || mq[i].addr !== ea[i] || mq[i].cyc != ec[i]) begin
        n_err++;
        $display("FAIL read_priority_cmd%0d: got wr=%0b addr=%h cyc=%0d required wr=%0b addr=%h cyc=%0d",
                 i, mq[i].wr, mq[i].addr, mq[i].cyc, ew[i], ea[i], ec[i]);
      end
    end
    n_cmp++;
    if (rq.size() != 1 || rq[0].data !== init_line(64)) begin
      n_err++; $display("FAIL read_priority_data: got %0d resps required 1 with init line 64", rq.size());
    end
  endtask

  task automatic test_youngest_match();
    int    a, rd_cnt;
    line_t d1, d2;
    clear_logs();
    d1 = rand_line();
    d2 = rand_line();
    send(1'b0, 32'h3C0, rand_line(), a);
    send(1'b0, 32'h400, d1, a);
    send(1'b0, 32'h400, d2, a);
    send(1'b1, 32'h400, '0, a);
    wait_idle("youngest");
    rd_cnt = 0;
    foreach (mq[i]) if (!mq[i].wr) rd_cnt++;
    n_cmp++; if (rd_cnt != (FWD ? 0 : 1)) begin n_err++; $display("FAIL youngest_rd_count: got %0d required %0d", rd_cnt, FWD ? 0 : 1); end
    n_cmp++;
    if (rq.size() != 1) begin
      n_err++; $display("FAIL youngest_resp_count: got %0d required 1", rq.size());
    end else begin
      n_cmp++;
      if (rq[0].data !== d2) begin n_err++; $display("FAIL youngest_data: got %h required %h", rq[0].data, d2); end
    end
  endtask

  task automatic test_random();
    int          a, nrd;
    bit          rd;
    logic [31:0] addr;
    clear_logs();
    nrd = 0;
    for (int i = 0; i < 80; i++) begin
      rd   = ($urandom_range(0, 2) == 0);
      addr = 32'h800 + 32'($urandom_range(0, 7)) * 32'h40 + 32'($urandom_range(0, 63));
      send(rd, addr, rand_line(), a);
      if (rd) nrd++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("random");
    n_cmp++;
    if (rq.size() != expq.size() || rq.size() != nrd) begin
      n_err++; $display("FAIL random_resp_count: got %0d required %0d", rq.size(), nrd);
    end
    for (int i = 0; i < rq.size() && i < expq.size(); i++) begin
      n_cmp++;
      if (rq[i].data !== expq[i]) begin
        n_err++; $display("FAIL random_read%0d_data: got %h required %h", i, rq[i].data, expq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int a, n, nev;
    clear_logs();
    send(1'b1, 32'h80, '0, a);
    n = 0;
    while (mq.size() == 0 && n < 50) begin @(negedge clk); n++; end
    n_cmp++; if (mq.size() == 0) begin n_err++; $display("FAIL reset_mid_read_issue: got no mem_rd required 1"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({resp_valid, mem_rd, mem_wr} !== 3'b000) begin n_err++; $display("FAIL midreset_pulses: got %b required 000", {resp_valid, mem_rd, mem_wr}); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== '0 || resp_rdata !== '0) begin n_err++; $display("FAIL midreset_data: got addr=%h required 0 on addr/wdata/rdata", mem_addr); end
    n_cmp++; if (wb_count !== 3'd0) begin n_err++; $display("FAIL midreset_wb_count: got %0d required 0", wb_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nev = mq.size();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midreset_req_ready: got %0b required 1", req_ready); end
    repeat (LAT + 10) @(negedge clk);
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL midreset_no_resp: got %0d resps required 0", rq.size()); end
    n_cmp++; if (mq.size() != nev) begin n_err++; $display("FAIL midreset_no_cmd: got %0d cmds required %0d", mq.size(), nev); end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (proto_err != 0) begin n_err++; $display("FAIL protocol_rules: got %0d violations required 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wb_fill();
    test_write_read();
    test_read_priority();
    test_youngest_match();
    test_random();
    test_reset_mid_read();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
